regfile_wb_arbiter: RTL and testbench

//  Write-side front end of the integer register file: collects results from NR_SRC producers (ALU, LSU, MULT, CSR...)

---
 rtl/regfile_wb_pkg.sv | 13 +
 rtl/regfile_wb_if.sv | 28 ++
 rtl/regfile_wb_rr_pick.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared widths and helpers for the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NR_FWD     = 2;

  // idx < 0 means nothing was granted, so the pointer stays where it was.
  function automatic int rr_next(input int ptr, input int idx, input int n);
    if (idx < 0) rr_next = ptr;
    else         rr_next = (idx + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Producer-result and register-file write-port bundle of the write-back arbiter.
interface regfile_wb_if
  import regfile_wb_pkg::*;
#(
  parameter int NR_SRC          = 4,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DATA_WIDTH      = 64
);

  logic [NR_SRC-1:0]                            src_valid_i;
  logic [NR_SRC-1:0]                            src_ready_o;
  logic [NR_SRC-1:0][REG_ADDR_W-1:0]            src_addr_i;
  logic [NR_SRC-1:0][DATA_WIDTH-1:0]            src_data_i;
  logic [NR_COMMIT_PORTS-1:0][REG_ADDR_W-1:0]   waddr_o;
  logic [NR_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]   wdata_o;
  logic [NR_COMMIT_PORTS-1:0]                   we_o;

  modport master (
    output src_valid_i, src_addr_i, src_data_i,
    input  src_ready_o, waddr_o, wdata_o, we_o
  );

  modport slave (
    input  src_valid_i, src_addr_i, src_data_i,
    output src_ready_o, waddr_o, wdata_o, we_o
  );

endinterface

// File: rtl/regfile_wb_rr_pick.sv
// Round-robin grant of up to NR_COMMIT_PORTS producers with same-register conflict masking.
module regfile_wb_rr_pick
  import regfile_wb_pkg::*;
#(
  parameter int NR_SRC          = 4,
  parameter int NR_COMMIT_PORTS = 2,
  localparam int PTR_W          = $clog2(NR_SRC),
  localparam int PW             = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1
) (
  input  logic [PTR_W-1:0]                  ptr_i,
  input  logic                              block_i,
  input  logic [NR_SRC-1:0]                 valid_i,
  input  logic [NR_SRC-1:0][REG_ADDR_W-1:0] addr_i,
  output logic [NR_SRC-1:0]                 grant_o,
  output logic [NR_SRC-1:0][PW-1:0]         port_o,
  output logic [PTR_W-1:0]                  ptr_o
);

  logic [REG_ADDR_W-1:0] taken [NR_COMMIT_PORTS];
  logic [PTR_W-1:0]      k;
  logic                  conflict;
  int                    cnt;
  int                    last;

  always_comb begin
    grant_o  = '0;
    port_o   = '0;
    k        = '0;
    conflict = 1'b0;
    cnt      = 0;
    last     = -1;
    for (int j = 0; j < NR_COMMIT_PORTS; j++) taken[j] = '0;

    for (int i = 0; i < NR_SRC; i++) begin
      k        = PTR_W'((int'(ptr_i) + i) % NR_SRC);
      conflict = 1'b0;
      // x0 is never written, so it can share a cycle with anything.
      for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
        if (j < cnt && addr_i[k] != '0 && taken[j] == addr_i[k]) conflict = 1'b1;
      end
      if (!block_i && valid_i[k] && cnt < NR_COMMIT_PORTS && !conflict) begin
        grant_o[k] = 1'b1;
        port_o[k]  = PW'(cnt);
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
          if (j == cnt) taken[j] = addr_i[k];
        end
        cnt  = cnt + 1;
        last = int'(k);
      end
    end

    ptr_o = PTR_W'(rr_next(int'(ptr_i), last, NR_SRC));
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: stages granted producer results one cycle ahead of the write ports.
// Optional forwarding from the staged writes is enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NR_SRC          = 4,
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DATA_WIDTH      = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  regfile_wb_if.slave                         bus,
`ifdef REGFILE_WB_FWD_EN
  input  logic [NR_FWD-1:0][REG_ADDR_W-1:0]   fwd_raddr_i,
  output logic [NR_FWD-1:0]                   fwd_hit_o,
  output logic [NR_FWD-1:0][DATA_WIDTH-1:0]   fwd_data_o,
`endif
  output logic                                busy_o
);

  localparam int PTR_W = $clog2(NR_SRC);
  localparam int PW    = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  wb_req_t [NR_COMMIT_PORTS-1:0] stg_q, stg_d;
  logic    [NR_COMMIT_PORTS-1:0] we_q, we_d;
  logic    [PTR_W-1:0]           ptr_q, ptr_d, ptr_nxt;
  logic    [NR_SRC-1:0]          grant;
  logic    [NR_SRC-1:0][PW-1:0]  port_sel;

  // Reset also blocks grants so no producer sees ready while the staging is cleared.
  regfile_wb_rr_pick #(
    .NR_SRC          (NR_SRC),
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS)
  ) u_pick (
    .ptr_i   (ptr_q),
    .block_i (rst_i | flush_i),
    .valid_i (bus.src_valid_i),
    .addr_i  (bus.src_addr_i),
    .grant_o (grant),
    .port_o  (port_sel),
    .ptr_o   (ptr_nxt)
  );

  assign bus.src_ready_o = grant;

  always_comb begin
    stg_d = stg_q;
    we_d  = '0;
    ptr_d = ptr_nxt;
    for (int k = 0; k < NR_SRC; k++) begin
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
        // An x0 grant consumes its port slot but leaves that port idle and unchanged.
        if (grant[k] && port_sel[k] == PW'(p) && bus.src_addr_i[k] != '0) begin
          we_d[p]       = 1'b1;
          stg_d[p].addr = bus.src_addr_i[k];
          stg_d[p].data = bus.src_data_i[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_q <= '0;
      we_q  <= '0;
      ptr_q <= '0;
    end else begin
      stg_q <= stg_d;
      we_q  <= we_d;
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      bus.waddr_o[p] = stg_q[p].addr;
      bus.wdata_o[p] = stg_q[p].data;
    end
  end

  assign bus.we_o = we_q;
  assign busy_o   = (|we_q) | (|bus.src_valid_i);

`ifdef REGFILE_WB_FWD_EN
  // Later ports override earlier ones so the highest-index match wins.
  always_comb begin
    fwd_hit_o  = '0;
    fwd_data_o = '0;
    for (int f = 0; f < NR_FWD; f++) begin
      for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
        if (we_q[p] && fwd_raddr_i[f] != '0 && stg_q[p].addr == fwd_raddr_i[f]) begin
          fwd_hit_o[f]  = 1'b1;
          fwd_data_o[f] = stg_q[p].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NR_SRC=4, 2 write ports, 64-bit data).
module tb_regfile_wb_arbiter;

  localparam int NS = 4;
  localparam int NP = 2;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_wb_if #(.NR_SRC(NS), .NR_COMMIT_PORTS(NP), .DATA_WIDTH(DW)) bus ();

`ifdef REGFILE_WB_FWD_EN
  logic [1:0][4:0]    fwd_raddr;
  logic [1:0]         fwd_hit;
  logic [1:0][DW-1:0] fwd_data;
`endif

  regfile_wb_arbiter #(.NR_SRC(NS), .NR_COMMIT_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .bus         (bus),
`ifdef REGFILE_WB_FWD_EN
    .fwd_raddr_i (fwd_raddr),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data),
`endif
    .busy_o      (busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    bus.src_valid_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.src_valid_i = 4'b1111;
    for (int i = 0; i < NS; i++) begin
      bus.src_addr_i[i] = 5'(i + 1);
      bus.src_data_i[i] = 64'h100 + 64'(i);
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.src_ready_o !== 4'b0000) begin
        failures++; $display("FAIL reset_ready c=%0d got=%b exp=0000", c, bus.src_ready_o);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.we_o !== 2'b00) begin
        failures++; $display("FAIL reset_we c=%0d got=%b exp=00", c, bus.we_o);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b0011) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=0011", bus.src_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b11 || bus.waddr_o[0] !== 5'd1 || bus.waddr_o[1] !== 5'd2 ||
        bus.wdata_o[0] !== 64'h100 || bus.wdata_o[1] !== 64'h101) begin
      failures++;
      $display("FAIL reset_release_write we=%b a0=%0d a1=%0d d0=%h d1=%h exp we=11 a0=1 a1=2 d0=100 d1=101",
               bus.we_o, bus.waddr_o[0], bus.waddr_o[1], bus.wdata_o[0], bus.wdata_o[1]);
    end
    @(negedge clk);
    bus.src_valid_i = '0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy [3];
    logic [4:0] exp_a0  [3];
    logic [4:0] exp_a1  [3];
    exp_rdy = '{4'b0011, 4'b1100, 4'b0011};
    exp_a0  = '{5'd1, 5'd3, 5'd1};
    exp_a1  = '{5'd2, 5'd4, 5'd2};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.src_valid_i = 4'b1111;
      for (int i = 0; i < NS; i++) begin
        bus.src_addr_i[i] = 5'(i + 1);
        bus.src_data_i[i] = 64'h1000 + 64'(i + 1);
      end
      #1;
      checks++;
      if (bus.src_ready_o !== exp_rdy[c]) begin
        failures++; $display("FAIL fair_ready c=%0d got=%b exp=%b", c, bus.src_ready_o, exp_rdy[c]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.we_o !== 2'b11 || bus.waddr_o[0] !== exp_a0[c] || bus.waddr_o[1] !== exp_a1[c] ||
          bus.wdata_o[0] !== 64'h1000 + 64'(exp_a0[c]) || bus.wdata_o[1] !== 64'h1000 + 64'(exp_a1[c])) begin
        failures++;
        $display("FAIL fair_write c=%0d we=%b a0=%0d a1=%0d exp we=11 a0=%0d a1=%0d",
                 c, bus.we_o, bus.waddr_o[0], bus.waddr_o[1], exp_a0[c], exp_a1[c]);
      end
    end
    @(negedge clk);
    bus.src_valid_i = '0;
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    bus.src_valid_i = 4'b0111;
    bus.src_addr_i[0] = 5'd5; bus.src_data_i[0] = 64'hAA;
    bus.src_addr_i[1] = 5'd5; bus.src_data_i[1] = 64'hBB;
    bus.src_addr_i[2] = 5'd6; bus.src_data_i[2] = 64'hCC;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b0101) begin
      failures++; $display("FAIL conflict_ready got=%b exp=0101", bus.src_ready_o);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL conflict_busy got=%b exp=1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b11 || bus.waddr_o[0] !== 5'd5 || bus.wdata_o[0] !== 64'hAA ||
        bus.waddr_o[1] !== 5'd6 || bus.wdata_o[1] !== 64'hCC) begin
      failures++;
      $display("FAIL conflict_first we=%b a0=%0d d0=%h a1=%0d d1=%h exp we=11 a0=5 d0=aa a1=6 d1=cc",
               bus.we_o, bus.waddr_o[0], bus.wdata_o[0], bus.waddr_o[1], bus.wdata_o[1]);
    end
    @(negedge clk);
    bus.src_valid_i = 4'b0010;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b0010) begin
      failures++; $display("FAIL conflict_second_ready got=%b exp=0010", bus.src_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b01 || bus.waddr_o[0] !== 5'd5 || bus.wdata_o[0] !== 64'hBB) begin
      failures++;
      $display("FAIL conflict_second we=%b a0=%0d d0=%h exp we=01 a0=5 d0=bb",
               bus.we_o, bus.waddr_o[0], bus.wdata_o[0]);
    end
    checks++;
    if (bus.waddr_o[1] !== 5'd6 || bus.wdata_o[1] !== 64'hCC) begin
      failures++;
      $display("FAIL idle_port_hold a1=%0d d1=%h exp a1=6 d1=cc", bus.waddr_o[1], bus.wdata_o[1]);
    end
    @(negedge clk);
    bus.src_valid_i = '0;
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    bus.src_valid_i = 4'b1100;
    bus.src_addr_i[2] = 5'd0; bus.src_data_i[2] = 64'hFF;
    bus.src_addr_i[3] = 5'd9; bus.src_data_i[3] = 64'h99;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b1100) begin
      failures++; $display("FAIL x0_ready got=%b exp=1100", bus.src_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b10 || bus.waddr_o[1] !== 5'd9 || bus.wdata_o[1] !== 64'h99) begin
      failures++;
      $display("FAIL x0_write we=%b a1=%0d d1=%h exp we=10 a1=9 d1=99", bus.we_o, bus.waddr_o[1], bus.wdata_o[1]);
    end
    @(negedge clk);
    bus.src_valid_i = 4'b0011;
    bus.src_addr_i[0] = 5'd0; bus.src_data_i[0] = 64'h11;
    bus.src_addr_i[1] = 5'd0; bus.src_data_i[1] = 64'h22;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b0011) begin
      failures++; $display("FAIL x0_pair_ready got=%b exp=0011", bus.src_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b00) begin
      failures++; $display("FAIL x0_pair_we got=%b exp=00", bus.we_o);
    end
    @(negedge clk);
    bus.src_valid_i = '0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    bus.src_valid_i = 4'b1011;
    bus.src_addr_i[0] = 5'd10; bus.src_data_i[0] = 64'hA0;
    bus.src_addr_i[1] = 5'd11; bus.src_data_i[1] = 64'hA1;
    bus.src_addr_i[3] = 5'd13; bus.src_data_i[3] = 64'hA3;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b0011) begin
      failures++; $display("FAIL flush_pre_ready got=%b exp=0011", bus.src_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b11 || bus.waddr_o[0] !== 5'd10 || bus.waddr_o[1] !== 5'd11) begin
      failures++;
      $display("FAIL flush_pre_write we=%b a0=%0d a1=%0d exp we=11 a0=10 a1=11", bus.we_o, bus.waddr_o[0], bus.waddr_o[1]);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b0000) begin
      failures++; $display("FAIL flush_ready got=%b exp=0000", bus.src_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b00 || bus.waddr_o[0] !== 5'd10) begin
      failures++; $display("FAIL flush_we we=%b a0=%0d exp we=00 a0=10", bus.we_o, bus.waddr_o[0]);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (bus.src_ready_o !== 4'b1001) begin
      failures++; $display("FAIL flush_resume_ready got=%b exp=1001", bus.src_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.we_o !== 2'b11 || bus.waddr_o[0] !== 5'd13 || bus.wdata_o[0] !== 64'hA3 ||
        bus.waddr_o[1] !== 5'd10 || bus.wdata_o[1] !== 64'hA0) begin
      failures++;
      $display("FAIL flush_resume_write we=%b a0=%0d a1=%0d exp we=11 a0=13 a1=10", bus.we_o, bus.waddr_o[0], bus.waddr_o[1]);
    end
    @(negedge clk);
    bus.src_valid_i = '0;
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic test_fwd();
    do_reset();
    @(negedge clk);
    fwd_raddr[0] = 5'd7;
    fwd_raddr[1] = 5'd0;
    bus.src_valid_i = 4'b0001;
    bus.src_addr_i[0] = 5'd7; bus.src_data_i[0] = 64'h1234;
    #1;
    checks++;
    if (fwd_hit !== 2'b00) begin
      failures++; $display("FAIL fwd_before got=%b exp=00", fwd_hit);
    end
    @(posedge clk); #1;
    checks++;
    if (fwd_hit !== 2'b01 || fwd_data[0] !== 64'h1234 || fwd_data[1] !== 64'h0) begin
      failures++;
      $display("FAIL fwd_hit hit=%b d0=%h d1=%h exp hit=01 d0=1234 d1=0", fwd_hit, fwd_data[0], fwd_data[1]);
    end
    @(negedge clk);
    bus.src_valid_i = '0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.src_valid_i = '0;
    bus.src_addr_i = '0;
    bus.src_data_i = '0;
`ifdef REGFILE_WB_FWD_EN
    fwd_raddr = '0;
`endif
    test_reset();
    test_fairness();
    test_conflict();
    test_x0();
    test_flush();
`ifdef REGFILE_WB_FWD_EN
    test_fwd();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
